// File: rtl/bus_transfer_sequencer_if.sv
// Command and strobe bundle for bus_transfer_sequencer.
// master: command issuer (drives inStart/inXchg/inSrc/inDst, observes strobes and status)
// slave : the sequencer (receives the command, drives outEnableOut/outLoad/outBusy/outDone/outError)
interface bus_transfer_sequencer_if #(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned SEL_W    = 3
);
    logic                inStart;
    logic                inXchg;
    logic [SEL_W-1:0]    inSrc;
    logic [SEL_W-1:0]    inDst;
    logic [NUM_REGS-1:0] outEnableOut;
    logic [NUM_REGS-1:0] outLoad;
    logic                outBusy;
    logic                outDone;
    logic                outError;

    modport master (
        output inStart, inXchg, inSrc, inDst,
        input  outEnableOut, outLoad, outBusy, outDone, outError
    );

    modport slave (
        input  inStart, inXchg, inSrc, inDst,
        output outEnableOut, outLoad, outBusy, outDone, outError
    );
endinterface

// File: rtl/bus_transfer_sequencer.sv
// Sequences register-to-register copies (MOV) and swaps through a scratch register (XCHG)
// over the shared W bus. Each transfer is a DRIVE cycle (source enabled, bus settles) followed
// by a LATCH cycle (source enabled, destination load strobe high).
// Ports:
//   inCLK      clock, rising edge
//   inReset_n  synchronous active-low reset
//   bus        slave side of bus_transfer_sequencer_if: command in, enable/load strobes and
//              busy/done/error status out. All outputs are flops.
module bus_transfer_sequencer #(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned SEL_W    = 3,
    parameter int unsigned TMP_IDX  = 7
) (
    input  logic                    inCLK,
    input  logic                    inReset_n,
    bus_transfer_sequencer_if.slave bus
);

    localparam int unsigned STEP_W = 2;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] LATCH = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [STEP_W-1:0] LAST_XCHG_STEP = STEP_W'(2);
    localparam logic [SEL_W-1:0]  TMP_SEL        = SEL_W'(TMP_IDX);

    logic [1:0]          state;
    logic [1:0]          stateNext;
    logic [STEP_W-1:0]   step;
    logic [STEP_W-1:0]   stepNext;
    logic                cmdXchg;
    logic                xchgNext;
    logic [SEL_W-1:0]    cmdSrc;
    logic [SEL_W-1:0]    srcNext;
    logic [SEL_W-1:0]    cmdDst;
    logic [SEL_W-1:0]    dstNext;
    logic                illegal;
    logic [SEL_W-1:0]    fromSel;
    logic [SEL_W-1:0]    toSel;
    logic [NUM_REGS-1:0] enableNext;
    logic [NUM_REGS-1:0] loadNext;
    logic                busyNext;
    logic                doneNext;
    logic                errorNext;

    // Next state plus the strobe pattern of that next state; outputs are then registered so
    // nothing combinational reaches the register file.
    always_comb begin
        stateNext  = state;
        stepNext   = step;
        xchgNext   = cmdXchg;
        srcNext    = cmdSrc;
        dstNext    = cmdDst;
        errorNext  = 1'b0;
        fromSel    = '0;
        toSel      = '0;
        enableNext = '0;
        loadNext   = '0;
        busyNext   = 1'b0;
        doneNext   = 1'b0;

        illegal = (bus.inSrc == bus.inDst)
               || (32'(bus.inSrc) >= NUM_REGS)
               || (32'(bus.inDst) >= NUM_REGS)
               || (bus.inXchg && ((bus.inSrc == TMP_SEL) || (bus.inDst == TMP_SEL)));

        case (state)
            IDLE, DONE: begin
                if (bus.inStart) begin
                    xchgNext = bus.inXchg;
                    srcNext  = bus.inSrc;
                    dstNext  = bus.inDst;
                    stepNext = '0;
                    if (illegal) begin
                        stateNext = DONE;
                        errorNext = 1'b1;
                    end else begin
                        stateNext = DRIVE;
                    end
                end else begin
                    stateNext = IDLE;
                end
            end
            DRIVE: begin
                stateNext = LATCH;
            end
            LATCH: begin
                if (cmdXchg && (step != LAST_XCHG_STEP)) begin
                    stateNext = DRIVE;
                    stepNext  = step + STEP_W'(1);
                end else begin
                    stateNext = DONE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        // Transfer endpoints for the upcoming step; XCHG rotates through the scratch register.
        if (xchgNext) begin
            case (stepNext)
                STEP_W'(0): begin
                    fromSel = srcNext;
                    toSel   = TMP_SEL;
                end
                STEP_W'(1): begin
                    fromSel = dstNext;
                    toSel   = srcNext;
                end
                default: begin
                    fromSel = TMP_SEL;
                    toSel   = dstNext;
                end
            endcase
        end else begin
            fromSel = srcNext;
            toSel   = dstNext;
        end

        busyNext = (stateNext == DRIVE) || (stateNext == LATCH);
        doneNext = (stateNext == DONE);
        if (busyNext) begin
            enableNext = NUM_REGS'(1) << fromSel;
        end
        if (stateNext == LATCH) begin
            loadNext = NUM_REGS'(1) << toSel;
        end
    end

    // State, latched command and registered outputs.
    always_ff @(posedge inCLK) begin
        if (!inReset_n) begin
            state            <= IDLE;
            step             <= '0;
            cmdXchg          <= 1'b0;
            cmdSrc           <= '0;
            cmdDst           <= '0;
            bus.outEnableOut <= '0;
            bus.outLoad      <= '0;
            bus.outBusy      <= 1'b0;
            bus.outDone      <= 1'b0;
            bus.outError     <= 1'b0;
        end else begin
            state            <= stateNext;
            step             <= stepNext;
            cmdXchg          <= xchgNext;
            cmdSrc           <= srcNext;
            cmdDst           <= dstNext;
            bus.outEnableOut <= enableNext;
            bus.outLoad      <= loadNext;
            bus.outBusy      <= busyNext;
            bus.outDone      <= doneNext;
            bus.outError     <= errorNext;
        end
    end

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Self-checking bench for bus_transfer_sequencer. A small register-file model sits on the
// W bus driven by the DUT strobes; expected per-cycle strobe/status words are queued when a
// command is driven and popped as the DUT produces each cycle.
module tb_bus_transfer_sequencer;

    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned SEL_W    = 3;
    localparam int unsigned TMP_IDX  = 7;

    typedef struct packed {
        logic [7:0] en;
        logic [7:0] ld;
        logic       busy;
        logic       done;
        logic       err;
    } obs_t;

    logic inCLK = 1'b0;
    logic inReset_n;

    bus_transfer_sequencer_if #(.NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) bus ();

    bus_transfer_sequencer #(
        .NUM_REGS(NUM_REGS),
        .SEL_W   (SEL_W),
        .TMP_IDX (TMP_IDX)
    ) dut (
        .inCLK    (inCLK),
        .inReset_n(inReset_n),
        .bus      (bus)
    );

    always #5 inCLK = ~inCLK;

    int   total = 0;
    int   bad   = 0;
    obs_t sb[$];

    // Register file model on the W bus.
    logic [7:0] regs [8];
    logic       preEn = 1'b0;
    logic [2:0] preIdx = 3'd0;
    logic [7:0] preVal = 8'h00;
    logic [7:0] wBus;

    always_comb begin
        wBus = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            if (bus.outEnableOut[i]) wBus = regs[i];
        end
    end

    always @(posedge inCLK) begin
        if (preEn) begin
            regs[preIdx] <= preVal;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (bus.outLoad[i]) regs[i] <= wBus;
            end
        end
    end

    function automatic obs_t mk(input logic [7:0] en, input logic [7:0] ld,
                                input logic busy, input logic done, input logic err);
        obs_t r;
        r.en = en; r.ld = ld; r.busy = busy; r.done = done; r.err = err;
        return r;
    endfunction

    // Preload one model register; called at a negedge with the DUT idle.
    task automatic setReg(input int idx, input logic [7:0] val);
        preEn  = 1'b1;
        preIdx = 3'(idx);
        preVal = val;
        @(negedge inCLK);
        preEn  = 1'b0;
    endtask

    task automatic drive(input logic st, input logic x, input int s, input int d);
        bus.inStart = st;
        bus.inXchg  = x;
        bus.inSrc   = 3'(s);
        bus.inDst   = 3'(d);
    endtask

    task automatic test_reset;
        obs_t e, o;
        inReset_n = 1'b0;
        drive(1'b1, 1'b0, 0, 1);
        repeat (2) sb.push_back(mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0));
        while (sb.size() > 0) begin
            @(negedge inCLK);
            e = sb.pop_front();
            o = {bus.outEnableOut, bus.outLoad, bus.outBusy, bus.outDone, bus.outError};
            total++;
            if (o !== e) begin bad++; $display("FAIL reset_hold got %h expected %h", o, e); end
        end
        inReset_n = 1'b1;
        drive(1'b0, 1'b0, 0, 1);
        repeat (2) sb.push_back(mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0));
        while (sb.size() > 0) begin
            @(negedge inCLK);
            e = sb.pop_front();
            o = {bus.outEnableOut, bus.outLoad, bus.outBusy, bus.outDone, bus.outError};
            total++;
            if (o !== e) begin bad++; $display("FAIL reset_release got %h expected %h", o, e); end
        end
    endtask

    task automatic test_mov;
        obs_t e, o;
        setReg(2, 8'h3C);
        setReg(5, 8'h00);
        drive(1'b1, 1'b0, 2, 5);
        sb.push_back(mk(8'h04, 8'h00, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(8'h04, 8'h20, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(8'h00, 8'h00, 1'b0, 1'b1, 1'b0));
        sb.push_back(mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0));
        while (sb.size() > 0) begin
            @(negedge inCLK);
            e = sb.pop_front();
            o = {bus.outEnableOut, bus.outLoad, bus.outBusy, bus.outDone, bus.outError};
            bus.inStart = 1'b0;
            total++;
            if (o !== e) begin bad++; $display("FAIL mov_seq got %h expected %h", o, e); end
        end
        total++;
        if (regs[5] !== 8'h3C) begin bad++; $display("FAIL mov_data reg5 got %h expected 3c", regs[5]); end
    endtask

    task automatic test_xchg;
        obs_t e, o;
        setReg(1, 8'hA5);
        setReg(3, 8'h5A);
        setReg(7, 8'h00);
        drive(1'b1, 1'b1, 1, 3);
        sb.push_back(mk(8'h02, 8'h00, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(8'h02, 8'h80, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(8'h08, 8'h00, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(8'h08, 8'h02, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(8'h80, 8'h00, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(8'h80, 8'h08, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(8'h00, 8'h00, 1'b0, 1'b1, 1'b0));
        sb.push_back(mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0));
        while (sb.size() > 0) begin
            @(negedge inCLK);
            e = sb.pop_front();
            o = {bus.outEnableOut, bus.outLoad, bus.outBusy, bus.outDone, bus.outError};
            bus.inStart = 1'b0;
            total++;
            if (o !== e) begin bad++; $display("FAIL xchg_seq got %h expected %h", o, e); end
        end
        total++;
        if (regs[1] !== 8'h5A) begin bad++; $display("FAIL xchg_reg1 got %h expected 5a", regs[1]); end
        total++;
        if (regs[3] !== 8'hA5) begin bad++; $display("FAIL xchg_reg3 got %h expected a5", regs[3]); end
        total++;
        if (regs[7] !== 8'hA5) begin bad++; $display("FAIL xchg_reg7 got %h expected a5", regs[7]); end
    endtask

    task automatic test_illegal;
        obs_t e, o;
        logic [6:0] cmds [3];
        cmds[0] = {1'b0, 3'd4, 3'd4};
        cmds[1] = {1'b1, 3'd7, 3'd0};
        cmds[2] = {1'b1, 3'd0, 3'd7};
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, cmds[c][6], int'(cmds[c][5:3]), int'(cmds[c][2:0]));
            sb.push_back(mk(8'h00, 8'h00, 1'b0, 1'b1, 1'b1));
            sb.push_back(mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0));
            while (sb.size() > 0) begin
                @(negedge inCLK);
                e = sb.pop_front();
                o = {bus.outEnableOut, bus.outLoad, bus.outBusy, bus.outDone, bus.outError};
                bus.inStart = 1'b0;
                total++;
                if (o !== e) begin bad++; $display("FAIL illegal_%0d got %h expected %h", c, o, e); end
            end
        end
    endtask

    task automatic test_back_to_back;
        obs_t e, o;
        int k;
        setReg(2, 8'h77);
        setReg(6, 8'h00);
        setReg(0, 8'h11);
        setReg(1, 8'h00);
        setReg(4, 8'h99);
        drive(1'b1, 1'b0, 2, 6);
        sb.push_back(mk(8'h04, 8'h00, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(8'h04, 8'h40, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(8'h00, 8'h00, 1'b0, 1'b1, 1'b0));
        sb.push_back(mk(8'h01, 8'h00, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(8'h01, 8'h02, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(8'h00, 8'h00, 1'b0, 1'b1, 1'b0));
        sb.push_back(mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0));
        k = 0;
        while (sb.size() > 0) begin
            @(negedge inCLK);
            e = sb.pop_front();
            o = {bus.outEnableOut, bus.outLoad, bus.outBusy, bus.outDone, bus.outError};
            // Start stays high: a stray legal MOV while busy, then the real follow-up in DONE.
            if (k < 2)       drive(1'b1, 1'b0, 3, 4);
            else if (k == 2) drive(1'b1, 1'b0, 0, 1);
            else             bus.inStart = 1'b0;
            total++;
            if (o !== e) begin bad++; $display("FAIL b2b_cycle%0d got %h expected %h", k, o, e); end
            total++;
            if ($countones(o.en) > 1 || $countones(o.ld) > 1 || (o.ld != 8'h00 && o.en == 8'h00)) begin
                bad++; $display("FAIL b2b_onehot cycle%0d en=%h ld=%h", k, o.en, o.ld);
            end
            k++;
        end
        total++;
        if (regs[6] !== 8'h77) begin bad++; $display("FAIL b2b_reg6 got %h expected 77", regs[6]); end
        total++;
        if (regs[1] !== 8'h11) begin bad++; $display("FAIL b2b_reg1 got %h expected 11", regs[1]); end
        total++;
        if (regs[4] !== 8'h99) begin bad++; $display("FAIL b2b_reg4 got %h expected 99", regs[4]); end
    endtask

    task automatic test_reset_mid;
        obs_t e, o;
        int k;
        setReg(1, 8'hA5);
        setReg(3, 8'h5A);
        drive(1'b1, 1'b1, 1, 3);
        sb.push_back(mk(8'h02, 8'h00, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(8'h02, 8'h80, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(8'h08, 8'h00, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(8'h08, 8'h02, 1'b1, 1'b0, 1'b0));
        repeat (5) sb.push_back(mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0));
        k = 0;
        while (sb.size() > 0) begin
            @(negedge inCLK);
            e = sb.pop_front();
            o = {bus.outEnableOut, bus.outLoad, bus.outBusy, bus.outDone, bus.outError};
            bus.inStart = 1'b0;
            if (k == 3) inReset_n = 1'b0;
            if (k == 4) inReset_n = 1'b1;
            total++;
            if (o !== e) begin bad++; $display("FAIL rstmid_cycle%0d got %h expected %h", k, o, e); end
            k++;
        end
        setReg(4, 8'hC3);
        setReg(6, 8'h00);
        drive(1'b1, 1'b0, 4, 6);
        sb.push_back(mk(8'h10, 8'h00, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(8'h10, 8'h40, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(8'h00, 8'h00, 1'b0, 1'b1, 1'b0));
        sb.push_back(mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0));
        while (sb.size() > 0) begin
            @(negedge inCLK);
            e = sb.pop_front();
            o = {bus.outEnableOut, bus.outLoad, bus.outBusy, bus.outDone, bus.outError};
            bus.inStart = 1'b0;
            total++;
            if (o !== e) begin bad++; $display("FAIL rstmid_mov got %h expected %h", o, e); end
        end
        total++;
        if (regs[6] !== 8'hC3) begin bad++; $display("FAIL rstmid_reg6 got %h expected c3", regs[6]); end
    endtask

    initial begin
        test_reset();
        test_mov();
        test_xchg();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_transfer_sequencer.md
# bus_transfer_sequencer

Sequencer that moves data between the SAP-2 registers over the shared 8-bit W bus. Each register provides a tri-state output enable and a load strobe that is captured on the clock's rising edge. This block drives those strobes for one command at a time, either MOV (single copy) or XCHG (swap through a scratch register). It guarantees that at most one register drives the bus in any cycle and that a destination register never loads while the bus is settling.

## Interface
Parameters:
- NUM_REGS, 8, number of bus-attached registers (valid indices 0..NUM_REGS-1)
- SEL_W, 3, width of register index fields
- TMP_IDX, 7, index of the scratch register used by XCHG

Ports:
- inCLK  input  1  clock; all state changes on rising edge
- inReset_n  input  1  reset, synchronous and active-low
- inStart  input  1  command request; accepted only when outBusy=0
- inXchg  input  1  0=MOV, 1=XCHG; sampled with inStart
- inSrc  input  SEL_W  source register index; sampled with inStart
- inDst  input  SEL_W  destination register index; sampled with inStart
- outEnableOut  output  NUM_REGS  one-hot or zero; drives register inEnableOut
- outLoad  output  NUM_REGS  one-hot or zero; drives register inLoad
- outBusy  output  1  command in progress
- outDone  output  1  one-cycle completion pulse
- outError  output  1  one-cycle pulse alongside outDone for a rejected command

## Operation
- States: IDLE, DRIVE, LATCH, DONE. A 2-bit step counter (0..2) tracks progress within an XCHG.
- Command latch: the block registers src, dst and mode when inStart=1 in IDLE or DONE.
- Illegal commands:
  - src==dst
  - src or dst >= NUM_REGS
  - XCHG with src==TMP_IDX or dst==TMP_IDX
- An illegal command goes straight to DONE with outError=1 and no strobes asserted.
- Transfer list:
  - MOV: src->dst.
  - XCHG: step0 src->TMP_IDX, step1 dst->src, step2 TMP_IDX->dst.
- Each transfer takes two cycles:
  - DRIVE: outEnableOut[from]=1, outLoad=0 (bus settles).
  - LATCH: outEnableOut[from]=1 and outLoad[to]=1. The target register captures on the rising edge that ends LATCH.
- Transitions:
  - IDLE -> DRIVE on a legal start.
  - DRIVE -> LATCH always.
  - LATCH -> DRIVE (step+1) if more transfers remain, else LATCH -> DONE.
  - DONE -> DRIVE on a legal start, DONE -> DONE on an illegal start, else DONE -> IDLE.
- Strobes are decoded from registered state only, so there are no combinational paths from inputs to outputs.
- outBusy=1 in DRIVE and LATCH, 0 in IDLE and DONE.
- outDone=1 only in DONE. outError=1 only in a DONE entered via an illegal command.
- The block ignores inStart while outBusy=1; the command is not queued.

## Timing
- Reset (inReset_n=0 at a rising edge) forces:
  - state=IDLE, step=0
  - outEnableOut=0, outLoad=0, outBusy=0, outDone=0, outError=0
- Reset mid-operation: all strobes are low from the next edge. A transfer whose LATCH edge coincides with reset is not guaranteed to load.
- Latency, with start sampled at edge E:
  - MOV: DRIVE in cycle E+1, LATCH in E+2, dst loaded at edge E+3, outDone in E+3.
  - XCHG: six strobe cycles (E+1..E+6), outDone in E+7.
  - Illegal command: outDone and outError in E+1.
- Back-to-back commands: a start during DONE makes the next cycle DRIVE, with no IDLE gap.
- Bus exclusivity: popcount(outEnableOut)<=1 and popcount(outLoad)<=1 every cycle. outLoad is never asserted without outEnableOut in the same cycle.

## Test plan
- Reset: hold inReset_n=0 for 2 cycles with inStart=1 -> all outputs 0, state IDLE. Release -> still idle until the next start.
- MOV src=2, dst=5 with reg2=0x3C -> outEnableOut=0x04 for 2 cycles, outLoad=0x20 in the second only. reg5=0x3C after edge E+3, outDone in E+3, outError=0.
- XCHG src=1, dst=3 with reg1=0xA5, reg3=0x5A -> enable/load pairs (0x02,0x80), (0x08,0x02), (0x80,0x08). Result reg1=0x5A, reg3=0xA5, reg7=0xA5, outDone in E+7.
- Illegal commands each give outDone=outError=1 at E+1 and never assert strobes:
  - MOV src=4, dst=4
  - XCHG src=7, dst=0
- Start held high throughout a MOV, then a new MOV 0->1 presented in the DONE cycle -> DRIVE immediately follows DONE. No start is accepted while outBusy=1, and one-hot checks pass every cycle.
- Reset asserted during the LATCH of XCHG step1 -> strobes 0 at the next edge, outDone never pulses. A fresh MOV afterwards completes normally.
